imem_axi_slave: RTL

//  AXI4 read-only slave that serves instruction fetches from a single-port SRAM macro.

---
 rtl/axi_pkg.sv | 30 +++
 rtl/axi_burst_addr.sv | 39 +++
 rtl/imem_axi_slave.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
//   Shared AXI4 definitions used by the slaves on the interconnect:
//   burst and response encodings, channel field widths, and the check for
//   a legal WRAP burst length.
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam int AXI_LEN_W  = 4;
    localparam int AXI_SIZE_W = 3;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
    function automatic logic is_wrap_len(input logic [AXI_LEN_W-1:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// ---------------------------------------------------------------------------
// axi_burst_addr
//   Combinational next-beat word address for an AXI4 burst, one word per beat.
//   Ports:
//     addr       in   AW         current beat word address
//     len        in   AXI_LEN_W  burst length field (beats-1)
//     burst      in   burst_t    burst type; the reserved encoding acts as INCR
//     next_addr  out  AW         word address of the following beat
//   INCR wraps modulo 2^AW; WRAP with an illegal length behaves as INCR.
// ---------------------------------------------------------------------------
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic [AW-1:0]        addr,
    input  logic [AXI_LEN_W-1:0] len,
    input  burst_t               burst,
    output logic [AW-1:0]        next_addr
);

    logic [AW-1:0] incr_addr;
    logic [AW-1:0] wrap_mask;

    assign incr_addr = addr + AW'(1);
    // For a legal wrap length, len is exactly the in-block offset mask.
    assign wrap_mask = AW'(len);

    // NOTE: default assignment first so every path drives next_addr and no latch is inferred.
    always_comb begin
        next_addr = incr_addr;
        case (burst)
            FIXED:   next_addr = addr;
            WRAP:    if (is_wrap_len(len)) next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/imem_axi_slave.sv
// ---------------------------------------------------------------------------
// imem_axi_slave
//   AXI4 read-only slave serving instruction fetches from a single-port SRAM.
//   Each beat costs one SRAM access cycle plus one capture cycle, so beats
//   are returned every 3 cycles when RREADY is held high.
//   Ports:
//     clk, rst                  clock, asynchronous active-high reset
//     AR*_S0                    read address channel (ARSIZE is ignored)
//     R*_S0                     read data channel, registered outputs
//     sram_cs/sram_oe/sram_a    SRAM control and word address
//     sram_do                   SRAM read data, valid one cycle after access
//   Configuration macro: IMEM_SLV_ADDR_CHECK_EN
//     defined   -> bursts outside the BASE_ADDR window return DECERR with zero
//                  data and never touch the SRAM
//     undefined -> upper address bits ignored (aliasing), RRESP always OKAY
// ---------------------------------------------------------------------------
module imem_axi_slave
    import axi_pkg::*;
#(
    parameter int          IDS_W     = 8,
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          SRAM_AW   = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDS_W-1:0]      ARID_S0,
    input  logic [ADDR_W-1:0]     ARADDR_S0,
    input  logic [AXI_LEN_W-1:0]  ARLEN_S0,
    input  logic [AXI_SIZE_W-1:0] ARSIZE_S0,
    input  logic [1:0]            ARBURST_S0,
    input  logic                  ARVALID_S0,
    output logic                  ARREADY_S0,
    output logic [IDS_W-1:0]      RID_S0,
    output logic [DATA_W-1:0]     RDATA_S0,
    output logic [1:0]            RRESP_S0,
    output logic                  RLAST_S0,
    output logic                  RVALID_S0,
    input  logic                  RREADY_S0,
    output logic                  sram_cs,
    output logic                  sram_oe,
    output logic [SRAM_AW-1:0]    sram_a,
    input  logic [DATA_W-1:0]     sram_do
);

    // One-hot state encoding.
    localparam logic [2:0] ST_IDLE    = 3'b001;
    localparam logic [2:0] ST_RD_ADDR = 3'b010;
    localparam logic [2:0] ST_RD_DATA = 3'b100;

    logic [2:0]           state;
    logic [IDS_W-1:0]     id_q;
    logic [SRAM_AW-1:0]   addr_q;
    logic [SRAM_AW-1:0]   addr_next;
    logic [AXI_LEN_W-1:0] len_q;
    logic [AXI_LEN_W-1:0] cnt_q;
    burst_t               burst_q;
    logic                 decerr_q;
    logic                 arready_q;
    logic                 rvalid_q;
    logic                 rlast_q;
    logic [DATA_W-1:0]    rdata_q;
    resp_t                rresp_q;

    logic ar_hs;
    logic addr_miss;

    assign ar_hs = ARVALID_S0 & arready_q;

`ifdef IMEM_SLV_ADDR_CHECK_EN
    assign addr_miss = ARADDR_S0[ADDR_W-1:SRAM_AW+2] != BASE_ADDR[ADDR_W-1:SRAM_AW+2];
    logic unused_ok;
    assign unused_ok = ^{ARSIZE_S0, ARADDR_S0[1:0]};
`else
    assign addr_miss = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{ARSIZE_S0, ARADDR_S0[1:0], ARADDR_S0[ADDR_W-1:SRAM_AW+2], BASE_ADDR};
`endif

    axi_burst_addr #(.AW(SRAM_AW)) u_burst_addr (
        .addr      (addr_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (addr_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            burst_q   <= INCR;
            decerr_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ar_hs) begin
                        id_q      <= ARID_S0;
                        addr_q    <= ARADDR_S0[SRAM_AW+1:2];
                        len_q     <= ARLEN_S0;
                        cnt_q     <= ARLEN_S0;
                        burst_q   <= burst_t'(ARBURST_S0);
                        decerr_q  <= addr_miss;
                        arready_q <= 1'b0;
                        state     <= ST_RD_ADDR;
                    end else begin
                        // Covers the first cycle after reset release.
                        arready_q <= 1'b1;
                    end
                end
                ST_RD_ADDR: begin
                    state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (!rvalid_q) begin
                        // Capture cycle: SRAM data from the access cycle is valid now.
                        rdata_q  <= decerr_q ? '0 : sram_do;
                        rresp_q  <= decerr_q ? DECERR : OKAY;
                        rlast_q  <= (cnt_q == '0);
                        rvalid_q <= 1'b1;
                    end else if (RREADY_S0) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (cnt_q == '0) begin
                            arready_q <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            cnt_q  <= cnt_q - 4'd1;
                            addr_q <= addr_next;
                            state  <= ST_RD_ADDR;
                        end
                    end
                end
                default: begin
                    // Illegal one-hot value: recover to a clean idle.
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                    rlast_q   <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign ARREADY_S0 = arready_q;
    assign RID_S0     = id_q;
    assign RDATA_S0   = rdata_q;
    assign RRESP_S0   = rresp_q;
    assign RLAST_S0   = rlast_q;
    assign RVALID_S0  = rvalid_q;

    // The SRAM is only touched in the access cycle; out-of-window bursts skip it.
    assign sram_cs = (state == ST_RD_ADDR) & ~decerr_q;
    assign sram_oe = sram_cs;
    assign sram_a  = addr_q;

endmodule
